pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_pkg.sv | 23 ++
 rtl/pc_stall_counter.sv | 33 +++
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_pkg
// Purpose  : Shared fetch-unit state encoding and default parameter values.
//            PC_STALL_CNT_EN, when defined, adds the stall_cnt output.
// Revision : 1.0  initial release
// ============================================================================
package pc_fetch_pkg;

    localparam int unsigned c_XLEN      = 32;
    localparam int unsigned c_RESET_VEC = 0;
    localparam int unsigned c_INC       = 4;
    localparam int unsigned c_CNT_W     = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        PEND  = 2'd2,
        HOLD  = 2'd3
    } pc_state_e;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_stall_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_stall_counter
// Purpose  : Saturating event counter for fetch stall cycles.
//            Only built when PC_STALL_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`ifdef PC_STALL_CNT_EN
module pc_stall_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Sticks at all-ones once reached rather than wrapping back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : pc_stall_counter
`endif
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program-counter sequencer issuing fetch requests to the ICACHE,
//            with redirect buffering and stall hold. PC_STALL_CNT_EN adds a
//            saturating stall_cnt output.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = c_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(c_RESET_VEC),
    parameter logic [XLEN-1:0] INC       = XLEN'(c_INC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_ready
`ifdef PC_STALL_CNT_EN
    ,
    output logic [c_CNT_W-1:0] stall_cnt
`endif
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    pc_state_e       w_state_after_hs;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_pend;
    logic [XLEN-1:0] w_pend_nxt;
    logic [XLEN-1:0] w_redir_tgt;
    logic            w_handshake;

    // INC is a power of two, so INC-1 masks exactly the sub-fetch offset bits.
    assign w_redir_tgt      = redirect_pc & ~(INC - XLEN'(1));
    assign fetch_valid      = (r_state == ISSUE) || (r_state == PEND);
    assign fetch_pc         = r_pc;
    assign w_handshake      = fetch_valid & fetch_ready;
    assign w_state_after_hs = stall ? HOLD : ISSUE;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        case (r_state)
            BOOT: begin
                if (redirect_valid) w_pc_nxt = w_redir_tgt;
                w_state_nxt = w_state_after_hs;
            end
            ISSUE: begin
                if (w_handshake) begin
                    w_pc_nxt    = redirect_valid ? w_redir_tgt : r_pc + INC;
                    w_state_nxt = w_state_after_hs;
                end else if (redirect_valid) begin
                    // Request in flight must stay stable; park the target.
                    w_pend_nxt  = w_redir_tgt;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (w_handshake) begin
                    w_pc_nxt    = redirect_valid ? w_redir_tgt : r_pend;
                    w_state_nxt = w_state_after_hs;
                end else if (redirect_valid) begin
                    w_pend_nxt = w_redir_tgt;
                end
            end
            HOLD: begin
                if (redirect_valid) w_pc_nxt = w_redir_tgt;
                if (!stall) w_state_nxt = ISSUE;
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

`ifdef PC_STALL_CNT_EN
    logic w_stall_evt;

    assign w_stall_evt = (r_state == HOLD) | (fetch_valid & ~fetch_ready);

    pc_stall_counter #(
        .WIDTH (c_CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_evt),
        .count (stall_cnt)
    );
`endif

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit (directed + random against
//            a reference model). Define PC_STALL_CNT_EN to include stall_cnt.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready = 1'b0;
`ifdef PC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: "booting" flag, issuing flag, PC, optional buffered redirect.
    bit          m_first;
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_has_pend;
    logic [31:0] m_pend;
    logic [31:0] m_cnt;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready)
`ifdef PC_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_first    = 1'b1;
        m_valid    = 1'b0;
        m_pc       = 32'h0;
        m_has_pend = 1'b0;
        m_pend     = 32'h0;
        m_cnt      = 32'h0;
    endtask

    task automatic model_edge(input bit s, input bit rv, input logic [31:0] rp, input bit rdy);
        logic [31:0] tgt;
        tgt = rp & ~32'h3;
        if (((!m_first) && (!m_valid)) || (m_valid && !rdy)) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        if (m_first) begin
            m_first = 1'b0;
            if (rv) m_pc = tgt;
            m_valid = !s;
        end else if (m_valid) begin
            if (rdy) begin
                m_pc       = rv ? tgt : (m_has_pend ? m_pend : m_pc + 32'd4);
                m_has_pend = 1'b0;
                m_valid    = !s;
            end else if (rv) begin
                m_has_pend = 1'b1;
                m_pend     = tgt;
            end
        end else begin
            if (rv) m_pc = tgt;
            if (!s) m_valid = 1'b1;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step(input bit s, input bit rv, input logic [31:0] rp, input bit rdy);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        fetch_ready    = rdy;
        @(posedge clk);
        model_edge(s, rv, rp, rdy);
        #1;
        chk("valid", {31'b0, fetch_valid}, {31'b0, m_valid});
        chk("pc", fetch_pc, m_pc);
`ifdef PC_STALL_CNT_EN
        chk("cnt", stall_cnt, m_cnt);
`endif
        @(negedge clk);
    endtask

    // Asserts reset off the clock edge, checks the asynchronous effect, releases at a falling edge.
    task automatic do_reset();
        #2;
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        fetch_ready    = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_pc", fetch_pc, 32'h0);
`ifdef PC_STALL_CNT_EN
        chk("rst_cnt", stall_cnt, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Sequential fetch from reset vector.
        step(0, 0, 32'h0, 1); chk("seq0", fetch_pc, 32'h0);
        step(0, 0, 32'h0, 1); chk("seq1", fetch_pc, 32'h4);
        step(0, 0, 32'h0, 1); chk("seq2", fetch_pc, 32'h8);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1); chk("at10", fetch_pc, 32'h10);

        // Not-ready hold with buffered, aligned redirect.
        step(0, 0, 32'h0, 0);   chk("hold_a", fetch_pc, 32'h10);
        step(0, 1, 32'h103, 0); chk("hold_b", fetch_pc, 32'h10);
        step(0, 0, 32'h0, 0);   chk("hold_c", fetch_pc, 32'h10);
        chk("hold_v", {31'b0, fetch_valid}, 32'h1);
        step(0, 0, 32'h0, 1);   chk("pend_hs", fetch_pc, 32'h100);

        // Newest buffered redirect wins.
        step(0, 1, 32'h200, 0);
        step(0, 1, 32'h300, 0);
        step(0, 0, 32'h0, 1);   chk("newest", fetch_pc, 32'h300);

        // Stall at handshake, redirect while held, then resume.
        step(0, 1, 32'h20, 1);  chk("at20", fetch_pc, 32'h20);
        step(1, 0, 32'h0, 1);   chk("stall_v", {31'b0, fetch_valid}, 32'h0);
        step(1, 1, 32'h40, 0);  chk("hold_redir", fetch_pc, 32'h40);
        step(0, 0, 32'h0, 0);   chk("resume_pc", fetch_pc, 32'h40);
        chk("resume_v", {31'b0, fetch_valid}, 32'h1);

        // Address wrap.
        step(0, 1, 32'hFFFF_FFFC, 1); chk("top", fetch_pc, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1);         chk("wrap", fetch_pc, 32'h0);

        // Reset in the middle of a pending redirect discards it.
        step(0, 1, 32'h500, 0);
        do_reset();
        step(0, 0, 32'h0, 1); chk("post_rst0", fetch_pc, 32'h0);
        step(0, 0, 32'h0, 1); chk("post_rst1", fetch_pc, 32'h4);

`ifdef PC_STALL_CNT_EN
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1);
        chk("cnt5", stall_cnt, 32'd5);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     $urandom, $urandom_range(0, 2) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
